cam_cfg_seq: RTL and testbench
==============================

# cam_cfg_seq

Parametrised camera bring-up sequencer: drives the sensor power-down/reset pins through a timed power-up sequence, then walks an external register table, issuing one I2C write per entry to `i2c_dri` through its exec/done handshake. It replaces the fixed OV5640 config path with a generic engine: any address width, any table depth, inline delay entries, NACK retry, restart on demand, and optional read-back verify. It sits between `i2c_dri` and a table ROM, clocked by `i2c_dri`'s `dri_clk`.

## Interface
- `ADDR_W`, 16: register address width; only 8 or 16 are legal.
- `TBL_DEPTH`, 256: number of table entries; `TBL_AW = $clog2(TBL_DEPTH)`.
- `DELAY_ADDR`, 16'hFFFF: an entry with this address is a delay entry, not an I2C write.
- `DELAY_UNIT`, 1000: clocks per delay count; 1000 gives 1 ms at a 1 MHz `dri_clk`.
- `PWDN_CYC`, 5000: clocks to hold `cam_pwdn=1` and `cam_rst_n=0`.
- `RST_CYC`, 1000: clocks to hold `cam_pwdn=0` and `cam_rst_n=0`.
- `SETTLE_CYC`, 20000: clocks after reset release before the first access.
- `MAX_RETRY`, 3: re-issues allowed per entry after a NACK.
- `clk` input 1: `dri_clk` from `i2c_dri`.
- `rst_n` input 1: asynchronous, active-low reset.
- `restart` input 1: single-cycle pulse that re-runs the whole sequence from power-down.
- `tbl_idx` output TBL_AW: current table index.
- `tbl_entry` input ADDR_W+8: `{addr, data}`, combinational from `tbl_idx`.
- `tbl_last` input 1: high when `tbl_idx` points at the final entry.
- `i2c_exec` output 1: one-cycle start pulse.
- `i2c_rh_wl` output 1: 1 = read, 0 = write.
- `i2c_addr` output ADDR_W: register address.
- `i2c_data_w` output 8: write data.
- `i2c_data_r` input 8: read data.
- `i2c_done` input 1: one-cycle completion pulse.
- `i2c_ack` input 1: NACK flag; 1 = slave did not acknowledge. Valid when `i2c_done` is high.
- `cam_pwdn` output 1: sensor power-down pin.
- `cam_rst_n` output 1: sensor reset pin.
- `init_done` output 1: table completed without error; stays high until reset or `restart`.
- `cfg_err` output 1: sticky error flag.
- `err_idx` output TBL_AW: table index of the first failing entry.

## Operation
- States: S_PWDN, S_RST, S_SETTLE, S_FETCH, S_EXEC, S_WAIT, S_VERIFY (macro only), S_DELAY, S_NEXT, S_DONE, S_ERR.
- Reset values:
  - state S_PWDN, with `cam_pwdn=1`, `cam_rst_n=0`.
  - `tbl_idx=0`, `i2c_exec=0`, `i2c_rh_wl=0`, `i2c_addr=0`, `i2c_data_w=0`.
  - `init_done=0`, `cfg_err=0`, `err_idx=0`.
  - one shared down-counter and the retry counter cleared.
- Power-up sequence: S_PWDN for PWDN_CYC clocks, then S_RST (`cam_pwdn=0`) for RST_CYC clocks, then S_SETTLE (`cam_rst_n=1`) for SETTLE_CYC clocks, then S_FETCH.
- S_FETCH, delay entry (address == DELAY_ADDR): load `data*DELAY_UNIT` into the counter and go to S_DELAY. A data value of 0 means no wait; go straight to S_NEXT.
- S_FETCH, write entry: register `i2c_addr`/`i2c_data_w`, set `i2c_rh_wl=0`, go to S_EXEC.
- S_EXEC: pulse `i2c_exec` for exactly one clock, then go to S_WAIT.
- S_WAIT, on `i2c_done` with `i2c_ack=1`:
  - If retries < MAX_RETRY: increment the retry counter and return to S_EXEC.
  - Otherwise: latch `err_idx` and go to S_ERR.
- S_WAIT, on `i2c_done` with `i2c_ack=0`: go to S_NEXT (or S_VERIFY with the macro).
- S_NEXT:
  - Clear the retry counter.
  - If `tbl_last`: go to S_DONE.
  - Otherwise: increment `tbl_idx` and go to S_FETCH.
- S_DONE: `init_done=1` and hold.
- S_ERR: `cfg_err=1`, `init_done=0`, and hold.
- `restart` is honoured in every state. It clears `tbl_idx`, `init_done`, `cfg_err`, `err_idx` and all counters, and enters S_PWDN.
- `i2c_done` is ignored outside S_WAIT and S_VERIFY.
- `tbl_idx` must not wrap. If `tbl_last` is never asserted and `tbl_idx == TBL_DEPTH-1`, treat that entry as the last one.
- For `ADDR_W=8`, `i2c_addr` carries the low byte only; `i2c_dri` runs with `bit_ctrl=0`.

## Timing
- `i2c_exec` rises 2 clocks after entry into S_FETCH (FETCH→EXEC→pulse).
- `i2c_addr`, `i2c_data_w` and `i2c_rh_wl` are stable from the cycle before `i2c_exec` until `i2c_done`.
- From `i2c_done` of entry n to `i2c_exec` of entry n+1: exactly 3 clocks (NEXT, FETCH, EXEC).
- A delay entry with value d occupies exactly `d*DELAY_UNIT` clocks in S_DELAY.
- `restart` together with `i2c_done` in the same cycle: `restart` wins. The in-flight transfer is abandoned; `i2c_dri` finishes it harmlessly while the sensor is powered down.
- `init_done` and `cfg_err` are registered and never high together.

## Configuration
- `CAM_CFG_VERIFY_EN` defined:
  - After each successful write, S_VERIFY issues a read: `i2c_rh_wl=1`, same address, one `i2c_exec` pulse.
  - On `i2c_done`, a mismatch between `i2c_data_r` and the written data, or a NACK, consumes one retry and restarts from the write.
  - When retries are exhausted: S_ERR.
- `CAM_CFG_VERIFY_EN` undefined: S_VERIFY and its read path are absent; `i2c_rh_wl` is tied to 0.

## Structure
- `cam_cfg_pkg` holds:
  - the state enum `cam_cfg_state_t`;
  - the `DELAY_ADDR` default;
  - the localparam `CNT_W`, sized for the largest of PWDN_CYC, RST_CYC, SETTLE_CYC and `255*DELAY_UNIT`.
- One natural sub-module, `cam_cfg_timer`: a loadable down-counter with a `zero` flag, shared by the power-up states and S_DELAY.
- The table ROM stays outside the block, so each sensor supplies its own ROM.

## Test plan
- Reset, then release. Required:
  - `cam_pwdn=1` and `cam_rst_n=0` for 5000 clocks;
  - `cam_pwdn=0` for the next 1000 clocks;
  - `cam_rst_n=1` from then on;
  - first `i2c_exec` 20002 clocks after `cam_rst_n` rises.
- 3-entry table {3008/82, FFFF/02, 3103/03}, all ACK. Required:
  - two write execs, with `i2c_addr=16'h3008` then `16'h3103`;
  - exactly 2000 idle clocks for the delay entry;
  - `init_done=1`, `cfg_err=0`.
- Entry 1 NACKs twice, then ACKs (MAX_RETRY=3). Required: 3 execs with identical address/data; sequence completes; `init_done=1`.
- Entry 5 always NACKs. Required: exactly 4 execs; `cfg_err=1`, `err_idx=5`, `init_done=0`.
- Pulse `restart` while in S_DONE, and again during S_WAIT. Required: both return to power-down and re-run from `tbl_idx=0`.
- With `CAM_CFG_VERIFY_EN`: read-back returns 8'h00 for a written 8'h42 on the first try, then 8'h42. Required:
  - sequence write, read, write, read;
  - the entry passes and the run ends with `init_done=1`.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared types and sizing for the camera bring-up sequencer.
// The S_VERIFY state exists only when CAM_CFG_VERIFY_EN is defined.
package cam_cfg_pkg;

   typedef enum logic [3:0] {
      S_PWDN,
      S_RST,
      S_SETTLE,
      S_FETCH,
      S_EXEC,
      S_WAIT,
`ifdef CAM_CFG_VERIFY_EN
      S_VERIFY,
`endif
      S_DELAY,
      S_NEXT,
      S_DONE,
      S_ERR
   } cam_cfg_state_t;

   localparam logic [15:0] DELAY_ADDR_DEF = 16'hFFFF;

   // Counter width covering every power-up phase and the longest delay entry.
   function automatic int cnt_width(input int pwdn, input int rst, input int settle,
                                    input int unit);
      int m;
      m = 255 * unit;
      if (pwdn > m)   m = pwdn;
      if (rst > m)    m = rst;
      if (settle > m) m = settle;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

   localparam int CNT_W = cnt_width(5000, 1000, 20000, 1000);

endpackage

// File: rtl/cam_cfg_timer.sv
// Loadable down-counter with a zero flag; it counts down on its own until it
// reaches zero, and a load always takes priority.
module cam_cfg_timer #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cam_cfg_seq.sv
// Camera bring-up sequencer: timed power-up, then one I2C write per table entry.
// Define CAM_CFG_VERIFY_EN to add a read-back check after every write.
module cam_cfg_seq
   import cam_cfg_pkg::*;
#(
   parameter int          ADDR_W     = 16,
   parameter int          TBL_DEPTH  = 256,
   parameter logic [15:0] DELAY_ADDR = DELAY_ADDR_DEF,
   parameter int          DELAY_UNIT = 1000,
   parameter int          PWDN_CYC   = 5000,
   parameter int          RST_CYC    = 1000,
   parameter int          SETTLE_CYC = 20000,
   parameter int          MAX_RETRY  = 3,
   localparam int         TBL_AW     = $clog2(TBL_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   output logic [TBL_AW-1:0] tbl_idx,
   input  logic [ADDR_W+7:0] tbl_entry,
   input  logic              tbl_last,
   output logic              i2c_exec,
   output logic              i2c_rh_wl,
   output logic [ADDR_W-1:0] i2c_addr,
   output logic [7:0]        i2c_data_w,
   input  logic [7:0]        i2c_data_r,
   input  logic              i2c_done,
   input  logic              i2c_ack,
   output logic              cam_pwdn,
   output logic              cam_rst_n,
   output logic              init_done,
   output logic              cfg_err,
   output logic [TBL_AW-1:0] err_idx,
   output logic [3:0]        dbg_state
);

   localparam int CW = cnt_width(PWDN_CYC, RST_CYC, SETTLE_CYC, DELAY_UNIT);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [ADDR_W-1:0] DLY_A   = DELAY_ADDR[ADDR_W-1:0];
   // PWDN spends one cycle arming the timer, hence the extra -1.
   localparam logic [CW-1:0]     PWDN_LD = CW'(PWDN_CYC - 2);
   localparam logic [CW-1:0]     RST_LD  = CW'(RST_CYC - 1);
   localparam logic [CW-1:0]     SET_LD  = CW'(SETTLE_CYC - 1);

   cam_cfg_state_t    state_q, state_d;
   logic [TBL_AW-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
   logic              exec_q, exec_d, done_q, done_d, err_q, err_d, arm_q, arm_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        dat_q, dat_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic              tmr_load, tmr_zero;
   logic [CW-1:0]     tmr_val;
   logic [ADDR_W-1:0] ent_addr;
   logic [7:0]        ent_data;
   logic              retry_ok, is_last;
`ifdef CAM_CFG_VERIFY_EN
   logic              rh_wl_q, rh_wl_d, vrd_q, vrd_d;
`endif

   assign ent_addr = tbl_entry[ADDR_W+7:8];
   assign ent_data = tbl_entry[7:0];
   assign retry_ok = (retry_q < RW'(MAX_RETRY));
   // Never wrap the index, even if the ROM forgets to flag its last entry.
   assign is_last  = tbl_last || (idx_q == TBL_AW'(TBL_DEPTH - 1));

   cam_cfg_timer #(.W(CW)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (tmr_load),
      .val_i  (tmr_val),
      .zero_o (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      exec_d    = 1'b0;
      addr_d    = addr_q;
      dat_d     = dat_q;
      done_d    = done_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;
      retry_d   = retry_q;
      arm_d     = arm_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
`ifdef CAM_CFG_VERIFY_EN
      rh_wl_d   = rh_wl_q;
      vrd_d     = vrd_q;
`endif
      if (restart) begin
         state_d   = S_PWDN;
         idx_d     = '0;
         done_d    = 1'b0;
         err_d     = 1'b0;
         err_idx_d = '0;
         retry_d   = '0;
         arm_d     = 1'b0;
         tmr_load  = 1'b1;
`ifdef CAM_CFG_VERIFY_EN
         rh_wl_d   = 1'b0;
         vrd_d     = 1'b0;
`endif
      end else begin
         case (state_q)
            S_PWDN: begin
               if (!arm_q) begin
                  arm_d    = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = PWDN_LD;
               end else if (tmr_zero) begin
                  state_d  = S_RST;
                  tmr_load = 1'b1;
                  tmr_val  = RST_LD;
               end
            end
            S_RST: if (tmr_zero) begin
               state_d  = S_SETTLE;
               tmr_load = 1'b1;
               tmr_val  = SET_LD;
            end
            S_SETTLE: if (tmr_zero) state_d = S_FETCH;
            S_FETCH: begin
               if (ent_addr == DLY_A) begin
                  if (ent_data == 8'd0) begin
                     state_d = S_NEXT;
                  end else begin
                     state_d  = S_DELAY;
                     tmr_load = 1'b1;
                     tmr_val  = (CW'(ent_data) * CW'(DELAY_UNIT)) - CW'(1);
                  end
               end else begin
                  addr_d  = ent_addr;
                  dat_d   = ent_data;
                  state_d = S_EXEC;
`ifdef CAM_CFG_VERIFY_EN
                  rh_wl_d = 1'b0;
`endif
               end
            end
            S_EXEC: begin
               exec_d  = 1'b1;
               state_d = S_WAIT;
            end
            S_WAIT: if (i2c_done) begin
               if (!i2c_ack) begin
`ifdef CAM_CFG_VERIFY_EN
                  state_d = S_VERIFY;
                  rh_wl_d = 1'b1;
                  vrd_d   = 1'b0;
`else
                  state_d = S_NEXT;
`endif
               end else if (retry_ok) begin
                  retry_d = retry_q + RW'(1);
                  state_d = S_EXEC;
               end else begin
                  err_idx_d = idx_q;
                  err_d     = 1'b1;
                  done_d    = 1'b0;
                  state_d   = S_ERR;
               end
            end
`ifdef CAM_CFG_VERIFY_EN
            // First cycle issues the read; afterwards wait for its completion.
            S_VERIFY: begin
               if (!vrd_q) begin
                  exec_d = 1'b1;
                  vrd_d  = 1'b1;
               end else if (i2c_done) begin
                  vrd_d   = 1'b0;
                  rh_wl_d = 1'b0;
                  if (!i2c_ack && (i2c_data_r == dat_q)) begin
                     state_d = S_NEXT;
                  end else if (retry_ok) begin
                     retry_d = retry_q + RW'(1);
                     state_d = S_EXEC;
                  end else begin
                     err_idx_d = idx_q;
                     err_d     = 1'b1;
                     done_d    = 1'b0;
                     state_d   = S_ERR;
                  end
               end
            end
`endif
            S_DELAY: if (tmr_zero) state_d = S_NEXT;
            S_NEXT: begin
               retry_d = '0;
               if (is_last) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + TBL_AW'(1);
                  state_d = S_FETCH;
               end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_PWDN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_PWDN;
         idx_q     <= '0;
         exec_q    <= 1'b0;
         addr_q    <= '0;
         dat_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
         retry_q   <= '0;
         arm_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         exec_q    <= exec_d;
         addr_q    <= addr_d;
         dat_q     <= dat_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
         retry_q   <= retry_d;
         arm_q     <= arm_d;
      end
   end

`ifdef CAM_CFG_VERIFY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rh_wl_q <= 1'b0;
         vrd_q   <= 1'b0;
      end else begin
         rh_wl_q <= rh_wl_d;
         vrd_q   <= vrd_d;
      end
   end
   assign i2c_rh_wl = rh_wl_q;
`else
   logic unused_data_r;
   assign unused_data_r = ^i2c_data_r;
   assign i2c_rh_wl     = 1'b0;
`endif

   assign tbl_idx    = idx_q;
   assign i2c_exec   = exec_q;
   assign i2c_addr   = addr_q;
   assign i2c_data_w = dat_q;
   assign cam_pwdn   = (state_q == S_PWDN);
   assign cam_rst_n  = !((state_q == S_PWDN) || (state_q == S_RST));
   assign init_done  = done_q;
   assign cfg_err    = err_q;
   assign err_idx    = err_idx_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Bench for cam_cfg_seq with shortened power-up/delay timings and a 16-entry table.
// Every I2C exec is checked against an expected queue filled by the stimulus.
module tb_cam_cfg_seq;
   import cam_cfg_pkg::*;

   localparam int DEPTH = 16;
   localparam int DU    = 10;
   localparam int PW    = 50;
   localparam int RC    = 10;
   localparam int SC    = 200;
   localparam int MR    = 3;
`ifdef CAM_CFG_VERIFY_EN
   localparam int VF = 2;
`else
   localparam int VF = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n, restart;
   logic [3:0]  tbl_idx, err_idx;
   logic [23:0] tbl_entry;
   logic        tbl_last;
   logic        i2c_exec, i2c_rh_wl, i2c_done, i2c_ack;
   logic [15:0] i2c_addr;
   logic [7:0]  i2c_data_w, i2c_data_r;
   logic        cam_pwdn, cam_rst_n, init_done, cfg_err;
   logic [3:0]  dbg_state;

   logic [24:0] exp_q[$];
   logic [24:0] mon_got, mon_exp;
   int total = 0, bad = 0, n_exec = 0, dly_cycles = 0;
   logic [23:0] tbl_mem [0:DEPTH-1];
   int  last_idx;
   int  nack_left [0:DEPTH-1];
   bit  nack_always [0:DEPTH-1];
   int  bad_reads = 0;
   logic [7:0] wr_last = 8'h00;

   always #5 clk = ~clk;

   assign tbl_entry = tbl_mem[tbl_idx];
   assign tbl_last  = (int'(tbl_idx) == last_idx);

   cam_cfg_seq #(
      .ADDR_W(16), .TBL_DEPTH(DEPTH), .DELAY_ADDR(16'hFFFF), .DELAY_UNIT(DU),
      .PWDN_CYC(PW), .RST_CYC(RC), .SETTLE_CYC(SC), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .restart(restart), .tbl_idx(tbl_idx),
      .tbl_entry(tbl_entry), .tbl_last(tbl_last), .i2c_exec(i2c_exec),
      .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w),
      .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
      .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .init_done(init_done),
      .cfg_err(cfg_err), .err_idx(err_idx), .dbg_state(dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every exec pulse pops one expected {rh_wl, addr, data}.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && i2c_exec === 1'b1) begin
         n_exec++;
         mon_got = {i2c_rh_wl, i2c_addr, i2c_data_w};
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL exec_unexpected: got %0h want none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("exec_txn", 32'(mon_got), 32'(mon_exp));
         end
      end
      if (dbg_state == 4'(S_DELAY)) dly_cycles++;
   end

   // I2C responder: done four cycles after exec, NACK pattern per table index.
   initial begin : responder
      int  idx;
      bit  rd, nack;
      i2c_done   = 1'b0;
      i2c_ack    = 1'b0;
      i2c_data_r = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && i2c_exec === 1'b1) begin
            idx = int'(tbl_idx);
            rd  = i2c_rh_wl;
            if (!rd) wr_last = i2c_data_w;
            repeat (4) @(negedge clk);
            nack = 1'b0;
            if (rd) begin
               i2c_data_r = (bad_reads > 0) ? 8'h00 : wr_last;
               if (bad_reads > 0) bad_reads--;
            end else if (nack_always[idx]) begin
               nack = 1'b1;
            end else if (nack_left[idx] > 0) begin
               nack = 1'b1;
               nack_left[idx]--;
            end
            i2c_done = 1'b1;
            i2c_ack  = nack;
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_ack  = 1'b0;
         end
      end
   end

   task automatic clr_plan();
      for (int i = 0; i < DEPTH; i++) begin
         nack_left[i]   = 0;
         nack_always[i] = 1'b0;
         tbl_mem[i]     = 24'h0;
      end
   endtask

   task automatic push_w(input logic [15:0] a, input logic [7:0] d);
      exp_q.push_back({1'b0, a, d});
   endtask

   task automatic push_ok(input logic [15:0] a, input logic [7:0] d);
      exp_q.push_back({1'b0, a, d});
`ifdef CAM_CFG_VERIFY_EN
      exp_q.push_back({1'b1, a, d});
`endif
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int c = 0;
      while (!(init_done || cfg_err) && c < 5000) begin
         @(negedge clk);
         c++;
      end
      total++;
      if (c >= 5000) begin
         bad++;
         $display("FAIL %s_timeout: got %0d cycles want <5000", name, c);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int c;
      rst_n   = 1'b0;
      restart = 1'b0;
      clr_plan();
      tbl_mem[0] = 24'h3008_82;
      tbl_mem[1] = 24'hFFFF_02;
      tbl_mem[2] = 24'h3103_03;
      last_idx = 2;
      push_ok(16'h3008, 8'h82);
      push_ok(16'h3103, 8'h03);
      repeat (3) @(negedge clk);
      chk("rst_pwdn", 32'(cam_pwdn), 1);
      chk("rst_cam_rst_n", 32'(cam_rst_n), 0);
      chk("rst_state", 32'(dbg_state), 32'(S_PWDN));
      chk("rst_tbl_idx", 32'(tbl_idx), 0);
      chk("rst_exec", 32'(i2c_exec), 0);
      chk("rst_addr", 32'(i2c_addr), 0);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      chk("rst_err_idx", 32'(err_idx), 0);

      // Power-up timing, counted in clock cycles from reset release.
      rst_n = 1'b1;
      c = 0;
      while (cam_pwdn === 1'b1 && c < PW * 4) begin
         c++;
         @(negedge clk);
      end
      chk("pwdn_cycles", 32'(c), PW);
      c = 0;
      while (cam_rst_n === 1'b0 && c < RC * 4) begin
         c++;
         @(negedge clk);
      end
      chk("rst_cycles", 32'(c), RC);
      c = 0;
      while (i2c_exec !== 1'b1 && c < SC * 4) begin
         @(negedge clk);
         c++;
      end
      chk("first_exec_lat", 32'(c), SC + 2);
      wait_end("t_table3");
      chk("t3_init_done", 32'(init_done), 1);
      chk("t3_cfg_err", 32'(cfg_err), 0);
      chk("t3_execs", 32'(n_exec), 2 * VF);
      chk("t3_delay_cycles", 32'(dly_cycles), 2 * DU);
      chk("t3_queue_empty", 32'(exp_q.size()), 0);

      // Entry 1 NACKs twice; restart issued from S_DONE.
      clr_plan();
      tbl_mem[0] = 24'h1000_11;
      tbl_mem[1] = 24'h1001_22;
      tbl_mem[2] = 24'h1002_33;
      last_idx = 2;
      nack_left[1] = 2;
      push_ok(16'h1000, 8'h11);
      push_w(16'h1001, 8'h22);
      push_w(16'h1001, 8'h22);
      push_ok(16'h1001, 8'h22);
      push_ok(16'h1002, 8'h33);
      n_exec = 0;
      pulse_restart();
      chk("rs_done_state", 32'(dbg_state), 32'(S_PWDN));
      chk("rs_done_pwdn", 32'(cam_pwdn), 1);
      chk("rs_done_init", 32'(init_done), 0);
      wait_end("t_nack2");
      chk("nack2_init_done", 32'(init_done), 1);
      chk("nack2_cfg_err", 32'(cfg_err), 0);
      chk("nack2_execs", 32'(n_exec), 2 + 3 * VF);
      chk("nack2_queue_empty", 32'(exp_q.size()), 0);

      // Entry 5 never ACKs: one try plus MAX_RETRY re-issues, then error.
      clr_plan();
      for (int i = 0; i < 6; i++) tbl_mem[i] = {16'h5000 + 16'(i), 8'h60 + 8'(i)};
      last_idx = 5;
      nack_always[5] = 1'b1;
      for (int i = 0; i < 5; i++) push_ok(16'h5000 + 16'(i), 8'h60 + 8'(i));
      for (int i = 0; i < MR + 1; i++) push_w(16'h5005, 8'h65);
      n_exec = 0;
      pulse_restart();
      wait_end("t_nack_all");
      chk("err_cfg_err", 32'(cfg_err), 1);
      chk("err_init_done", 32'(init_done), 0);
      chk("err_err_idx", 32'(err_idx), 5);
      chk("err_execs", 32'(n_exec), 5 * VF + 4);
      chk("err_queue_empty", 32'(exp_q.size()), 0);

      // Restart while a write is outstanding in S_WAIT.
      clr_plan();
      tbl_mem[0] = 24'h2000_AA;
      tbl_mem[1] = 24'h2001_BB;
      last_idx = 1;
      push_w(16'h2000, 8'hAA);
      pulse_restart();
      chk("rs_err_cfg_err", 32'(cfg_err), 0);
      chk("rs_err_err_idx", 32'(err_idx), 0);
      c = 0;
      while (i2c_exec !== 1'b1 && c < 1000) begin
         @(negedge clk);
         c++;
      end
      chk("rs_wait_reached", 32'(dbg_state), 32'(S_WAIT));
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("rs_wait_state", 32'(dbg_state), 32'(S_PWDN));
      chk("rs_wait_tbl_idx", 32'(tbl_idx), 0);
      n_exec = 0;
      push_ok(16'h2000, 8'hAA);
      push_ok(16'h2001, 8'hBB);
      wait_end("t_rs_wait");
      chk("rs_wait_init_done", 32'(init_done), 1);
      chk("rs_wait_execs", 32'(n_exec), 2 * VF);
      chk("rs_wait_queue_empty", 32'(exp_q.size()), 0);

      // No tbl_last at all: the final table slot ends the run without wrapping.
      clr_plan();
      for (int i = 0; i < DEPTH; i++) tbl_mem[i] = {16'h4000 + 16'(i), 8'(i * 3)};
      last_idx = -1;
      for (int i = 0; i < DEPTH; i++) push_ok(16'h4000 + 16'(i), 8'(i * 3));
      n_exec = 0;
      pulse_restart();
      wait_end("t_nowrap");
      chk("nowrap_init_done", 32'(init_done), 1);
      chk("nowrap_tbl_idx", 32'(tbl_idx), DEPTH - 1);
      chk("nowrap_execs", 32'(n_exec), DEPTH * VF);
      chk("nowrap_queue_empty", 32'(exp_q.size()), 0);

`ifdef CAM_CFG_VERIFY_EN
      // First read-back returns 00 instead of 42: write, read, write, read.
      clr_plan();
      tbl_mem[0] = 24'h3008_42;
      last_idx = 0;
      bad_reads = 1;
      push_ok(16'h3008, 8'h42);
      push_ok(16'h3008, 8'h42);
      n_exec = 0;
      pulse_restart();
      wait_end("t_verify");
      chk("verify_init_done", 32'(init_done), 1);
      chk("verify_cfg_err", 32'(cfg_err), 0);
      chk("verify_execs", 32'(n_exec), 4);
      chk("verify_queue_empty", 32'(exp_q.size()), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
